// File: rtl/mult_div_unit_if.sv
// Bundle between the control unit / register bank and the multiply/divide unit.
// Optional MDU_DIV0_FLAG_EN adds the div0 completion flag.
//
// Handshake: start is a request that the unit samples only while it is idle
// (busy=0). An accepted request raises busy from the following edge until the
// result edge. On the result edge hi/lo update and done pulses for exactly one
// cycle, with busy already low. A new start may be presented in that done cycle.
interface mult_div_unit_if #(parameter int DATA_W = 32);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] operand_a;
  logic [DATA_W-1:0] operand_b;
  logic              hi_we;
  logic              lo_we;
  logic [DATA_W-1:0] wdata;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
`ifdef MDU_DIV0_FLAG_EN
  logic              div0;
`endif

  modport master (
    output start, op, operand_a, operand_b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
`ifdef MDU_DIV0_FLAG_EN
    , input div0
`endif
  );

  modport slave (
    input  start, op, operand_a, operand_b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
`ifdef MDU_DIV0_FLAG_EN
    , output div0
`endif
  );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO.
// MULT/MULTU use shift-add; DIV/DIVU use restoring shift-subtract on magnitudes,
// followed by a sign-correction cycle. Latency: DATA_W+2 edges from accept.
// Optional MDU_DIV0_FLAG_EN: div0 pulses with done when a divide had divisor 0.
module mult_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  mult_div_unit_if.slave        bus,
  output logic [1:0]            dbgState
);
  localparam int CW = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE = 2'd0, PREP = 2'd1, CALC = 2'd2, FIN = 2'd3} state_t;
  state_t state, stateNext;

  logic [1:0]          opQ;
  logic [DATA_W-1:0]   aRaw, bRaw;     // operands exactly as latched at accept
  logic [DATA_W-1:0]   opnd;           // multiplicand or divisor magnitude
  logic [2*DATA_W-1:0] prod;           // product, or {remainder, quotient}
  logic                signQ, signR;
  logic [CW-1:0]       cnt;
  logic [DATA_W-1:0]   hiR, loR;
  logic                doneR;
`ifdef MDU_DIV0_FLAG_EN
  logic                div0R;
`endif

  logic              isDiv, isSigned, lastIter;
  logic [DATA_W-1:0] magA, magB, quot, rem;
  logic [DATA_W:0]   mulSum, shifted, diff;
  logic [2*DATA_W-1:0] prodNeg;

  assign isDiv    = opQ[1];
  assign isSigned = ~opQ[0];
  assign lastIter = (cnt == CW'(DATA_W - 1));
  assign magA     = (isSigned && aRaw[DATA_W-1]) ? -aRaw : aRaw;
  assign magB     = (isSigned && bRaw[DATA_W-1]) ? -bRaw : bRaw;
  // One shift-add step: conditionally add the multiplicand into the upper half.
  assign mulSum   = {1'b0, prod[2*DATA_W-1:DATA_W]} + (prod[0] ? {1'b0, opnd} : '0);
  // One restoring step: shift the next dividend bit into the partial remainder.
  assign shifted  = {prod[2*DATA_W-1:DATA_W], prod[DATA_W-1]};
  assign diff     = shifted - {1'b0, opnd};
  assign quot     = prod[DATA_W-1:0];
  assign rem      = prod[2*DATA_W-1:DATA_W];
  assign prodNeg  = -prod;

  assign bus.busy = (state == CALC) || (state == FIN);
  assign bus.done = doneR;
  assign bus.hi   = hiR;
  assign bus.lo   = loR;
`ifdef MDU_DIV0_FLAG_EN
  assign bus.div0 = div0R;
`endif
  assign dbgState = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state logic: IDLE -> PREP -> CALC x DATA_W -> FIN -> IDLE.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (bus.start) stateNext = PREP;
      PREP:    stateNext = CALC;
      CALC:    if (lastIter) stateNext = FIN;
      FIN:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, sign correction and HI/LO writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      opQ   <= '0;
      aRaw  <= '0;
      bRaw  <= '0;
      opnd  <= '0;
      prod  <= '0;
      signQ <= 1'b0;
      signR <= 1'b0;
      cnt   <= '0;
      hiR   <= '0;
      loR   <= '0;
      doneR <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
      div0R <= 1'b0;
`endif
    end else begin
      doneR <= 1'b0;
`ifdef MDU_DIV0_FLAG_EN
      div0R <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.hi_we) hiR <= bus.wdata;
          if (bus.lo_we) loR <= bus.wdata;
          if (bus.start) begin
            opQ  <= bus.op;
            aRaw <= bus.operand_a;
            bRaw <= bus.operand_b;
          end
        end
        PREP: begin
          signQ <= isSigned & (aRaw[DATA_W-1] ^ bRaw[DATA_W-1]);
          signR <= isSigned & aRaw[DATA_W-1];
          cnt   <= '0;
          if (isDiv) begin
            opnd <= magB;
            prod <= {{DATA_W{1'b0}}, magA};
          end else begin
            opnd <= magA;
            prod <= {{DATA_W{1'b0}}, magB};
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (isDiv) begin
            if (!diff[DATA_W]) prod <= {diff[DATA_W-1:0], prod[DATA_W-2:0], 1'b1};
            else               prod <= {shifted[DATA_W-1:0], prod[DATA_W-2:0], 1'b0};
          end else begin
            prod <= {mulSum, prod[DATA_W-1:1]};
          end
        end
        FIN: begin
          cnt   <= '0;
          doneR <= 1'b1;
          if (isDiv) begin
            // Divide by zero returns all-ones quotient and the dividend untouched.
            if (bRaw == '0) begin
              loR <= '1;
              hiR <= aRaw;
`ifdef MDU_DIV0_FLAG_EN
              div0R <= 1'b1;
`endif
            end else begin
              loR <= signQ ? -quot : quot;
              hiR <= signR ? -rem : rem;
            end
          end else begin
            {hiR, loR} <= signQ ? prodNeg : prod;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit with hand-computed HI/LO results.
module tb_mult_div_unit;
  localparam int DATA_W = 32;

  logic       clk;
  logic       rst;
  logic [1:0] dbgState;
  int         n_compared;
  int         n_mismatched;
  logic [63:0] exp_q[$];

  mult_div_unit_if #(.DATA_W(DATA_W)) bus ();

  mult_div_unit #(.DATA_W(DATA_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbgState (dbgState)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no end, required finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    end
  endtask

  // advance one active edge, then settle
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start     = 1'b1;
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    tick();
    bus.start = 1'b0;
  endtask

  // waits for done after start_op; returns edges since accept and busy cycles
  task automatic wait_done(output int edges, output int busy_cycles);
    edges = 0;
    busy_cycles = 0;
    while (edges < 100) begin
      tick();
      edges++;
      if (bus.done) break;
      if (bus.busy) busy_cycles++;
    end
  endtask

  task automatic check_result(input string tag, input logic exp_div0);
    logic [63:0] e;
    e = exp_q.pop_front();
    check({tag, ".done"}, 64'(bus.done), 64'd1);
    check({tag, ".busy"}, 64'(bus.busy), 64'd0);
    check({tag, ".hi"}, 64'(bus.hi), 64'(e[63:32]));
    check({tag, ".lo"}, 64'(bus.lo), 64'(e[31:0]));
`ifdef MDU_DIV0_FLAG_EN
    check({tag, ".div0"}, 64'(bus.div0), 64'(exp_div0));
`else
    if (exp_div0 === 1'bx) $display("note: div0 unknown");
`endif
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_div0);
    int edges, bc;
    exp_q.push_back({exp_hi, exp_lo});
    start_op(op, a, b);
    wait_done(edges, bc);
    check({tag, ".latency"}, 64'(edges), 64'd34);
    check_result(tag, exp_div0);
  endtask

  initial begin
    int edges, bc, done_seen;
    n_compared = 0;
    n_mismatched = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op = 2'b00;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    tick();
    tick();
    rst = 1'b0;

    // reset state
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.done", 64'(bus.done), 64'd0);
    check("rst.hi", 64'(bus.hi), 64'd0);
    check("rst.lo", 64'(bus.lo), 64'd0);
    check("rst.state", 64'(dbgState), 64'd0);

    // MULTU max x max with latency and busy-width checks
    exp_q.push_back({32'hFFFF_FFFE, 32'h0000_0001});
    start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu.prep_state", 64'(dbgState), 64'd1);
    check("multu.prep_busy", 64'(bus.busy), 64'd0);
    wait_done(edges, bc);
    check("multu.latency", 64'(edges), 64'd34);
    check("multu.busy_cycles", 64'(bc), 64'd33);
    check_result("multu", 1'b0);

    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op("mult_min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, 1'b0);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_op("divu_zero", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1);
    tick();
    check("divu_zero.done_after", 64'(bus.done), 64'd0);
`ifdef MDU_DIV0_FLAG_EN
    check("divu_zero.div0_after", 64'(bus.div0), 64'd0);
`endif
    run_op("div_zero", 2'b10, 32'hFFFF_FFF0, 32'd0, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1);

    // MTHI / MTLO in IDLE, separately and together
    bus.hi_we = 1'b1;
    bus.wdata = 32'hAAAA_0001;
    tick();
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h5555_0002;
    tick();
    bus.lo_we = 1'b0;
    check("mthi", 64'(bus.hi), 64'hAAAA_0001);
    check("mtlo", 64'(bus.lo), 64'h5555_0002);
    bus.hi_we = 1'b1;
    bus.lo_we = 1'b1;
    bus.wdata = 32'hC0DE_0003;
    tick();
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    check("mthilo.hi", 64'(bus.hi), 64'hC0DE_0003);
    check("mthilo.lo", 64'(bus.lo), 64'hC0DE_0003);

    // start together with MTHI: write happens, result later overwrites HI
    bus.hi_we = 1'b1;
    bus.wdata = 32'h0000_0077;
    exp_q.push_back({32'h0, 32'd12});
    start_op(2'b01, 32'd3, 32'd4);
    bus.hi_we = 1'b0;
    check("start_mthi.hi", 64'(bus.hi), 64'h77);
    wait_done(edges, bc);
    check("start_mthi.latency", 64'(edges), 64'd34);
    check_result("start_mthi", 1'b0);

    // start and MTHI while busy are ignored; operands change mid-flight
    exp_q.push_back({32'h1, 32'h0});
    start_op(2'b01, 32'h0001_0000, 32'h0001_0000);
    edges = 0;
    while (edges < 100) begin
      if (edges == 4) begin
        bus.start = 1'b1;
        bus.op = 2'b11;
        bus.operand_a = 32'd9;
        bus.operand_b = 32'd3;
      end
      if (edges == 5) begin
        bus.start = 1'b0;
        bus.hi_we = 1'b1;
        bus.wdata = 32'h0000_1234;
      end
      if (edges == 6) bus.hi_we = 1'b0;
      tick();
      edges++;
      if (bus.done) break;
    end
    check("busy_ignore.latency", 64'(edges), 64'd34);
    check_result("busy_ignore", 1'b0);

    // back-to-back start in the done cycle
    run_op("b2b", 2'b11, 32'd9, 32'd3, 32'd0, 32'd3, 1'b0);

    // reset in the middle of a DIV aborts with no later done
    start_op(2'b10, 32'd1000, 32'd3);
    for (int i = 0; i < 9; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort.busy", 64'(bus.busy), 64'd0);
    check("abort.done", 64'(bus.done), 64'd0);
    check("abort.hi", 64'(bus.hi), 64'd0);
    check("abort.lo", 64'(bus.lo), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) done_seen++;
    end
    check("abort.no_done", 64'(done_seen), 64'd0);
    run_op("after_abort", 2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
